// File: rtl/axi_err_pkg.sv
// Shared AXI response codes and FSM state types for the terminating error slave.
package axi_err_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

endpackage

// File: rtl/axi_err_slv_sync.sv
// Terminating AXI4 slave for unmapped addresses: drains every burst and answers it
// with a fixed error response, counting terminated transactions in a saturating counter.
module axi_err_slv_sync
  import axi_err_pkg::*;
#(
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned DataWidth = 64,
  parameter logic [1:0]  Resp      = RESP_DECERR,
  parameter logic [63:0] RespData  = 64'hBADC_AB1E_BADC_AB1E,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 aw_valid_i,
  output logic                 aw_ready_o,
  input  logic [IdWidth-1:0]   aw_id_i,
  input  logic                 w_valid_i,
  output logic                 w_ready_o,
  input  logic                 w_last_i,
  output logic                 b_valid_o,
  input  logic                 b_ready_i,
  output logic [IdWidth-1:0]   b_id_o,
  output logic [1:0]           b_resp_o,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [7:0]           ar_len_i,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o,
  output logic [CntWidth-1:0]  err_cnt_o,
  input  logic                 cnt_clr_i
);

  localparam int unsigned            SumWidth = CntWidth + 1;
  localparam logic [DataWidth-1:0]   RDataPat = DataWidth'(RespData);

  w_state_e              r_wr_state;
  w_state_e              w_wr_state_nxt;
  r_state_e              r_rd_state;
  r_state_e              w_rd_state_nxt;
  logic [IdWidth-1:0]    r_b_id;
  logic [IdWidth-1:0]    r_r_id;
  logic [7:0]            r_beat_cnt;
  logic [7:0]            w_beat_cnt_nxt;
  logic [CntWidth-1:0]   r_err_cnt;
  logic [CntWidth-1:0]   w_err_cnt_nxt;
  logic [SumWidth-1:0]   w_cnt_sum;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_b_hs;
  logic                  w_ar_hs;
  logic                  w_r_hs;

  // Handshake-facing outputs come from state only; reset masks them so nothing
  // is offered or accepted while the slave is being cleared.
  assign aw_ready_o = (r_wr_state == W_IDLE) & ~rst_i;
  assign w_ready_o  = (r_wr_state == W_DATA) & ~rst_i;
  assign b_valid_o  = (r_wr_state == W_RESP) & ~rst_i;
  assign ar_ready_o = (r_rd_state == R_IDLE) & ~rst_i;
  assign r_valid_o  = (r_rd_state == R_DATA) & ~rst_i;
  assign r_last_o   = (r_rd_state == R_DATA) & (r_beat_cnt == 8'd0);

  assign b_id_o    = r_b_id;
  assign b_resp_o  = Resp;
  assign r_id_o    = r_r_id;
  assign r_data_o  = RDataPat;
  assign r_resp_o  = Resp;
  assign err_cnt_o = r_err_cnt;

  assign w_aw_hs = aw_valid_i & aw_ready_o;
  assign w_w_hs  = w_valid_i  & w_ready_o;
  assign w_b_hs  = b_valid_o  & b_ready_i;
  assign w_ar_hs = ar_valid_i & ar_ready_o;
  assign w_r_hs  = r_valid_o  & r_ready_i;

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    unique case (r_wr_state)
      W_IDLE:  if (w_aw_hs) w_wr_state_nxt = W_DATA;
      W_DATA:  if (w_w_hs && w_last_i) w_wr_state_nxt = W_RESP;
      W_RESP:  if (w_b_hs) w_wr_state_nxt = W_IDLE;
      default: w_wr_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_beat_cnt_nxt = r_beat_cnt;
    unique case (r_rd_state)
      R_IDLE: begin
        if (w_ar_hs) begin
          w_rd_state_nxt = R_DATA;
          w_beat_cnt_nxt = ar_len_i;
        end
      end
      R_DATA: begin
        if (w_r_hs) begin
          w_beat_cnt_nxt = r_beat_cnt - 8'd1;
          if (r_last_o) w_rd_state_nxt = R_IDLE;
        end
      end
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  // One extra sum bit catches any overflow, including a double increment from all-ones.
  always_comb begin
    w_cnt_sum     = {1'b0, r_err_cnt} + SumWidth'(w_aw_hs) + SumWidth'(w_ar_hs);
    w_err_cnt_nxt = r_err_cnt;
    if (cnt_clr_i) begin
      w_err_cnt_nxt = '0;
    end else if (w_cnt_sum[CntWidth]) begin
      w_err_cnt_nxt = '1;
    end else begin
      w_err_cnt_nxt = w_cnt_sum[CntWidth-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_state <= W_IDLE;
      r_rd_state <= R_IDLE;
      r_b_id     <= '0;
      r_r_id     <= '0;
      r_beat_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_rd_state <= w_rd_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_err_cnt  <= w_err_cnt_nxt;
      if (w_aw_hs) r_b_id <= aw_id_i;
      if (w_ar_hs) r_r_id <= ar_id_i;
    end
  end

endmodule

// File: tb/tb_axi_err_slv_sync.sv
// Self-checking bench for axi_err_slv_sync: directed scenarios followed by randomized
// traffic, all compared cycle by cycle against a transaction-level reference model.
module tb_axi_err_slv_sync;

  localparam int          ID_W    = 4;
  localparam int          DATA_W  = 64;
  localparam int          CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [63:0] PATTERN = 64'hBADC_AB1E_BADC_AB1E;

  logic              clk;
  logic              rst;
  logic              awValid, awReady, wValid, wReady, wLast;
  logic              bValid, bReady, arValid, arReady;
  logic              rValid, rReady, rLast, cntClr;
  logic [ID_W-1:0]   awId, bId, arId, rId;
  logic [7:0]        arLen;
  logic [1:0]        bResp, rResp;
  logic [DATA_W-1:0] rData;
  logic [CNT_W-1:0]  errCnt;

  int testCount = 0;
  int failCount = 0;

  // Reference model: where each transaction stands, not how the RTL encodes it.
  bit              wrActive, bPending;
  int              rdBeatsLeft, expErrCnt;
  logic [ID_W-1:0] bIdExp, rIdExp;
  bit              awHsM, wHsM, bHsM, arHsM, rHsM;
  int              bHsCount, rHsCount, rLastHsCount;
  int              wBeatIdx, wBurstLen;

  axi_err_slv_sync #(
    .IdWidth  (ID_W),
    .DataWidth(DATA_W),
    .CntWidth (CNT_W)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .aw_valid_i(awValid),
    .aw_ready_o(awReady),
    .aw_id_i   (awId),
    .w_valid_i (wValid),
    .w_ready_o (wReady),
    .w_last_i  (wLast),
    .b_valid_o (bValid),
    .b_ready_i (bReady),
    .b_id_o    (bId),
    .b_resp_o  (bResp),
    .ar_valid_i(arValid),
    .ar_ready_o(arReady),
    .ar_id_i   (arId),
    .ar_len_i  (arLen),
    .r_valid_o (rValid),
    .r_ready_i (rReady),
    .r_id_o    (rId),
    .r_data_o  (rData),
    .r_resp_o  (rResp),
    .r_last_o  (rLast),
    .err_cnt_o (errCnt),
    .cnt_clr_i (cntClr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    wrActive    = 0;
    bPending    = 0;
    rdBeatsLeft = 0;
    expErrCnt   = 0;
  endtask

  // One clock: check outputs mid-cycle, advance the model across the edge, then
  // return just after the edge so the caller can drive the next cycle's inputs.
  task automatic applyStimulus();
    bit expAwReady, expWReady, expBValid, expArReady, expRValid;
    @(negedge clk);
    expAwReady = !rst && !wrActive;
    expWReady  = !rst && wrActive && !bPending;
    expBValid  = !rst && bPending;
    expArReady = !rst && (rdBeatsLeft == 0);
    expRValid  = !rst && (rdBeatsLeft > 0);
    checkOutput("aw_ready", awReady, expAwReady);
    checkOutput("w_ready", wReady, expWReady);
    checkOutput("b_valid", bValid, expBValid);
    checkOutput("ar_ready", arReady, expArReady);
    checkOutput("r_valid", rValid, expRValid);
    checkOutput("err_cnt", errCnt, expErrCnt);
    if (expBValid) begin
      checkOutput("b_id", bId, bIdExp);
      checkOutput("b_resp", bResp, 2'b11);
    end
    if (expRValid) begin
      checkOutput("r_id", rId, rIdExp);
      checkOutput("r_data", rData, PATTERN);
      checkOutput("r_resp", rResp, 2'b11);
      checkOutput("r_last", rLast, rdBeatsLeft == 1);
    end
    if (bValid === 1'b1 && bReady) bHsCount++;
    if (rValid === 1'b1 && rReady) begin
      rHsCount++;
      if (rLast === 1'b1) rLastHsCount++;
    end
    awHsM = awValid && expAwReady;
    wHsM  = wValid && expWReady;
    bHsM  = expBValid && bReady;
    arHsM = arValid && expArReady;
    rHsM  = expRValid && rReady;
    if (rst) begin
      resetModel();
    end else begin
      if (bHsM) begin
        wrActive = 0;
        bPending = 0;
      end
      if (wHsM && wLast) bPending = 1;
      if (awHsM) begin
        wrActive = 1;
        bIdExp   = awId;
      end
      if (arHsM) begin
        rdBeatsLeft = int'(arLen) + 1;
        rIdExp      = arId;
      end else if (rHsM) begin
        rdBeatsLeft--;
      end
      if (cntClr) expErrCnt = 0;
      else begin
        expErrCnt = expErrCnt + int'(awHsM) + int'(arHsM);
        if (expErrCnt > CNT_MAX) expErrCnt = CNT_MAX;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clearStats();
    bHsCount     = 0;
    rHsCount     = 0;
    rLastHsCount = 0;
  endtask

  initial begin
    {awValid, wValid, wLast, bReady, arValid, rReady, cntClr} = '0;
    awId  = '0;
    arId  = '0;
    arLen = '0;
    rst   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    resetModel();
    clearStats();
    applyStimulus();
    rst = 1'b0;
    applyStimulus();

    // Single write: AW id 3, four W beats, B one cycle after the last beat.
    awValid = 1'b1;
    awId    = 4'd3;
    bReady  = 1'b1;
    applyStimulus();
    awValid = 1'b0;
    wValid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wLast = (i == 3);
      applyStimulus();
    end
    wValid = 1'b0;
    wLast  = 1'b0;
    checkOutput("wr_no_early_b", bHsCount, 0);
    applyStimulus();
    checkOutput("wr_b_timing", bHsCount, 1);
    checkOutput("wr_errcnt", errCnt, 1);

    // Read burst len 7 with r_ready held: eight back-to-back beats.
    clearStats();
    arValid = 1'b1;
    arId    = 4'd5;
    arLen   = 8'd7;
    rReady  = 1'b1;
    applyStimulus();
    arValid = 1'b0;
    repeat (7) applyStimulus();
    checkOutput("rd_beats7", rHsCount, 7);
    checkOutput("rd_nolast7", rLastHsCount, 0);
    applyStimulus();
    checkOutput("rd_beats8", rHsCount, 8);
    checkOutput("rd_last8", rLastHsCount, 1);
    applyStimulus();

    // Same read with r_ready toggling; beats must hold while stalled.
    clearStats();
    arValid = 1'b1;
    applyStimulus();
    arValid = 1'b0;
    for (int c = 0; c < 40 && rHsCount < 8; c++) begin
      rReady = (c % 2 == 0);
      applyStimulus();
    end
    checkOutput("bp_beats", rHsCount, 8);
    checkOutput("bp_last", rLastHsCount, 1);
    rReady = 1'b1;
    repeat (3) applyStimulus();
    checkOutput("bp_no_extra", rHsCount, 8);

    // Bring the counter to CntMax-1 with single-beat reads.
    cntClr = 1'b1;
    applyStimulus();
    cntClr = 1'b0;
    arLen  = 8'd0;
    for (int n = 0; n < CNT_MAX - 1; n++) begin
      arValid = 1'b1;
      arId    = ID_W'($urandom);
      applyStimulus();
      arValid = 1'b0;
      applyStimulus();
    end
    checkOutput("pre_sat", errCnt, CNT_MAX - 1);

    // Simultaneous AW and AR: +2 from CntMax-1 saturates; both complete independently.
    clearStats();
    awValid = 1'b1;
    awId    = ID_W'($urandom);
    arValid = 1'b1;
    arId    = ID_W'($urandom);
    arLen   = 8'd2;
    applyStimulus();
    awValid = 1'b0;
    arValid = 1'b0;
    checkOutput("sat_cnt", errCnt, CNT_MAX);
    wValid = 1'b1;
    wBeatIdx = 0;
    for (int c = 0; c < 20 && (bHsCount < 1 || rHsCount < 3); c++) begin
      wLast = (wBeatIdx == 1);
      applyStimulus();
      if (wHsM) wBeatIdx++;
      if (wBeatIdx == 2) wValid = 1'b0;
    end
    wLast = 1'b0;
    checkOutput("conc_b", bHsCount, 1);
    checkOutput("conc_r", rHsCount, 3);
    applyStimulus();
    arValid = 1'b1;
    applyStimulus();
    checkOutput("sat_hold", errCnt, CNT_MAX);
    arValid = 1'b0;
    repeat (4) applyStimulus();

    // Clear wins over a same-cycle increment.
    arValid = 1'b1;
    cntClr  = 1'b1;
    applyStimulus();
    arValid = 1'b0;
    cntClr  = 1'b0;
    checkOutput("clr_prio", errCnt, 0);
    repeat (4) applyStimulus();

    // Reset after the second of eight R beats abandons the burst.
    clearStats();
    arValid = 1'b1;
    arId    = 4'd9;
    arLen   = 8'd7;
    applyStimulus();
    arValid = 1'b0;
    for (int c = 0; c < 10 && rHsCount < 2; c++) applyStimulus();
    checkOutput("rst_pre_beats", rHsCount, 2);
    rst = 1'b1;
    repeat (2) applyStimulus();
    rst = 1'b0;
    repeat (10) applyStimulus();
    checkOutput("rst_no_more_r", rHsCount, 2);
    checkOutput("rst_errcnt", errCnt, 0);

    // Randomized traffic with AXI-legal valid holding and occasional resets.
    {awValid, wValid, wLast, bReady, arValid, rReady, cntClr} = '0;
    wBeatIdx  = 0;
    wBurstLen = $urandom_range(1, 4);
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 599) == 0);
      if (rst) begin
        {awValid, wValid, wLast, arValid} = '0;
        wBeatIdx = 0;
      end else begin
        if (!awValid || awHsM) begin
          awValid = ($urandom_range(0, 2) == 0);
          awId    = ID_W'($urandom);
        end
        if (wHsM) begin
          if (wLast) begin
            wBeatIdx  = 0;
            wBurstLen = $urandom_range(1, 4);
          end else begin
            wBeatIdx++;
          end
        end
        if (!wValid || wHsM) wValid = ($urandom_range(0, 1) == 0);
        wLast = (wBeatIdx == wBurstLen - 1);
        if (!arValid || arHsM) begin
          arValid = ($urandom_range(0, 2) == 0);
          arId    = ID_W'($urandom);
          arLen   = 8'($urandom_range(0, 7));
        end
      end
      bReady = $urandom_range(0, 1);
      rReady = $urandom_range(0, 1);
      cntClr = ($urandom_range(0, 31) == 0);
      applyStimulus();
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
